pwm_generator: RTL
==================

// Module: pwm_generator
// PURPOSE
//  Power-stage PWM generator: consumes the on-time command Time_on from the
//  averaging regulator and drives the complementary high/low switch gates with dead-time.
//  Emits a one-cycle ADC sample strobe at mid on-time, so the regulator sees
//  ripple-centred V_battery samples. On-time updates only at period boundaries.
// PARAMETERS
//  PERIOD    500  switching period in clk_1M cycles (2..1023)
//  TON_MAX   460  upper clamp on applied on-time (TON_MAX+2*DEAD <= PERIOD)
//  TON_MIN   0    lower clamp on applied on-time
//  DEAD      2    dead-time in cycles between hi falling and lo rising, and vice versa
// PORTS
//  clk_1M        in   1   1 MHz system clock, all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  enable        in   1   1 = run switching, 0 = gates off
//  Time_on       in   10  requested on-time in cycles (from regulator)
//  pwm_hi        out  1   high-side gate drive
//  pwm_lo        out  1   low-side gate drive (complementary, dead-time separated)
//  sample_trig   out  1   1-cycle ADC sample strobe at mid on-time
//  period_start  out  1   1-cycle pulse at first cycle of each period
//  ton_applied   out  10  on-time in force for the current period
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): state=IDLE, cnt=0, all outputs 0, ton_applied=0.
//   Applies mid-operation too: every output 0 on the cycle after the edge.
//  States: IDLE, RUN.
//   IDLE: outputs 0, cnt held 0. enable=1 -> RUN; on that edge cnt<=0,
//    ton_applied<=clamp(Time_on).
//   RUN: cnt increments each cycle; at cnt==PERIOD-1 wraps to 0 and
//    ton_applied<=clamp(Time_on) sampled on that same edge (new value rules next period).
//    enable=0 -> IDLE on next edge; gates 0 the cycle after; no period completion.
//  clamp(x): x>TON_MAX -> TON_MAX; x<TON_MIN -> TON_MIN; else x. Unsigned 10-bit compare.
//  Time_on changes mid-period are ignored until the wrap edge.
//  Outputs are registered and decoded from cnt (value after the edge), T=ton_applied:
//   pwm_hi = RUN && cnt < T            -> exactly T high cycles per period; T=0 -> never.
//   pwm_lo = RUN && cnt >= T+DEAD && cnt < PERIOD-DEAD; empty range -> never high.
//   sample_trig = RUN && cnt == (T>>1)  (T=0 -> at cnt 0; T=1 -> at cnt 0).
//   period_start = RUN && cnt == 0.
//  Invariant: pwm_hi && pwm_lo never both 1; >= DEAD zero cycles at each transition,
//   including across the wrap (lo ends PERIOD-DEAD, hi restarts at 0).
//  Latency: enable rising -> period_start and (if T>0) pwm_hi high 1 cycle later.
//  Width: cnt 10 bits; T+DEAD evaluated in 11 bits (no wrap).
// TESTING
//  1 rst, enable=1, Time_on=100 -> pwm_hi 100 cycles high, pwm_lo cnt 102..497,
//    sample_trig at cnt 50, period_start every 500 cycles.
//  2 Time_on=1000 -> ton_applied=460, pwm_hi 460 cycles, pwm_lo cnt 462..497;
//    Time_on=0 -> pwm_hi never, pwm_lo cnt 2..497, sample_trig at cnt 0.
//  3 Time_on 100->300 at cnt 250 -> current period keeps 100;
//    next period 300 from period_start.
//  4 rst pulse at cnt 50 in RUN -> all outputs 0 next cycle, state IDLE,
//    restart on enable with cnt 0.
//  5 enable dropped at cnt 10 -> gates 0 next cycle; enable re-raised ->
//    fresh period, clamp(Time_on) reloaded.
//  6 random Time_on every cycle, 10k cycles -> assert never pwm_hi&&pwm_lo,
//    >=2 idle cycles at every gate change.

Source files
------------

// File: rtl/pwm_generator.sv
// pwm_generator: complementary high/low gate PWM with dead-time, mid-on-time ADC strobe
// and on-time updates taken only at period boundaries.
module pwm_generator #(
    parameter int PERIOD  = 500,
    parameter int TON_MAX = 460,
    parameter int TON_MIN = 0,
    parameter int DEAD    = 2
) (
    input  logic       clk_1M,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] Time_on,
    output logic       pwm_hi,
    output logic       pwm_lo,
    output logic       sample_trig,
    output logic       period_start,
    output logic [9:0] ton_applied
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [9:0]  CNT_LAST = 10'(PERIOD - 1);
    localparam logic [9:0]  LO_END   = 10'(PERIOD - DEAD);
    localparam logic [9:0]  T_MAX    = 10'(TON_MAX);
    localparam logic [9:0]  T_MIN    = 10'(TON_MIN);
    localparam logic [10:0] DEAD_W   = 11'(DEAD);

    state_t     state, state_n;
    logic [9:0] cnt, cnt_n, ton_n, ton_clamped;
    logic       run_n;
    logic [10:0] lo_start;

    always_comb begin
        ton_clamped = Time_on >= T_MAX ? T_MAX : Time_on <= T_MIN ? T_MIN : Time_on;
        state_n     = state;
        cnt_n       = cnt;
        ton_n       = ton_applied;
        if (state == IDLE) begin
            state_n = enable ? RUN : IDLE;
            cnt_n   = '0;
            ton_n   = enable ? ton_clamped : '0;
        end else if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            ton_n   = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_n = '0;
            ton_n = ton_clamped;
        end else begin
            cnt_n = cnt + 10'd1;
        end
        run_n    = state_n == RUN;
        // 11-bit sum so a large on-time cannot wrap into the low-side window
        lo_start = {1'b0, ton_n} + DEAD_W;
    end

    // Outputs are decoded from the post-edge count so they line up with cnt
    always_ff @(posedge clk_1M) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ton_applied  <= '0;
            pwm_hi       <= 1'b0;
            pwm_lo       <= 1'b0;
            sample_trig  <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            ton_applied  <= ton_n;
            pwm_hi       <= run_n && cnt_n < ton_n;
            pwm_lo       <= run_n && {1'b0, cnt_n} >= lo_start && cnt_n < LO_END;
            sample_trig  <= run_n && cnt_n == (ton_n >> 1);
            period_start <= run_n && cnt_n == 10'd0;
        end
    end
endmodule
